// File: rtl/dcache_req_driver.sv
// CPU-side request initiator for data-cache benches: queues read/write/read-check commands and replays them on the cache handshake.
// Optional read-check comparator and error counter are built only when DCACHE_DRIVER_CHECK_EN is defined.
module dcache_req_driver #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 200
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [1:0] CMD_OP,
  input  logic [7:0] CMD_ADDRESS,
  input  logic [7:0] CMD_DATA,
  output logic       MEM_READ,
  output logic       MEM_WRITE,
  output logic [7:0] MEM_ADDRESS,
  output logic [7:0] MEM_WRITE_DATA,
  input  logic [7:0] MEM_READ_DATA,
  input  logic       MEM_BUSY_WAIT,
  output logic       RSP_VALID,
  output logic [7:0] RSP_DATA,
  output logic [7:0] RSP_LATENCY,
  output logic       RSP_MISMATCH,
  output logic [7:0] ERR_COUNT,
  output logic       TIMED_OUT,
  output logic       IDLE
);

  localparam int             PW         = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]    FULL_COUNT = (PW + 1)'(FIFO_DEPTH);
  localparam logic [7:0]     TIMEOUT_C  = 8'(TIMEOUT);
  localparam logic [1:0]     OP_WRITE   = 2'b01;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HALT} state_t;

  state_t                 state_reg;
  logic [17:0]            fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr_reg;
  logic [PW-1:0]          rd_ptr_reg;
  logic [PW:0]            count_reg;
  logic [FIFO_DEPTH-1:0]  wr_en;

  logic       mem_read_reg;
  logic       mem_write_reg;
  logic [7:0] mem_address_reg;
  logic [7:0] mem_write_data_reg;
  logic [1:0] op_reg;
  logic [7:0] lat_reg;
  logic       rsp_valid_reg;
  logic [7:0] rsp_data_reg;
  logic [7:0] rsp_latency_reg;
  logic       timed_out_reg;

  logic        push;
  logic        pop;
  logic        complete;
  logic [17:0] head;
  logic [7:0]  lat_inc;

  assign CMD_READY = (count_reg != FULL_COUNT);
  assign push      = CMD_VALID && CMD_READY;
  assign pop       = (state_reg == S_IDLE) && (count_reg != '0);
  assign head      = fifo_mem[rd_ptr_reg];
  assign complete  = (state_reg == S_REQ) && !MEM_BUSY_WAIT;
  assign lat_inc   = (lat_reg == 8'hFF) ? 8'hFF : lat_reg + 8'd1;

  // One write-enable per queue slot; storage itself is never reset, the pointers define validity.
  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_wr_en
    assign wr_en[gi] = push && (wr_ptr_reg == PW'(gi));
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (wr_en[i]) begin
        fifo_mem[i] <= {CMD_OP, CMD_ADDRESS, CMD_DATA};
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (PW + 1)'(1);
        2'b01:   count_reg <= count_reg - (PW + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg          <= S_IDLE;
      mem_read_reg       <= 1'b0;
      mem_write_reg      <= 1'b0;
      mem_address_reg    <= '0;
      mem_write_data_reg <= '0;
      op_reg             <= '0;
      lat_reg            <= '0;
      rsp_valid_reg      <= 1'b0;
      rsp_data_reg       <= '0;
      rsp_latency_reg    <= '0;
      timed_out_reg      <= 1'b0;
    end else begin
      rsp_valid_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (pop) begin
            op_reg             <= head[17:16];
            mem_address_reg    <= head[15:8];
            mem_write_data_reg <= head[7:0];
            mem_write_reg      <= (head[17:16] == OP_WRITE);
            mem_read_reg       <= (head[17:16] != OP_WRITE);
            lat_reg            <= '0;
            state_reg          <= S_REQ;
          end
        end
        S_REQ: begin
          if (complete) begin
            mem_read_reg    <= 1'b0;
            mem_write_reg   <= 1'b0;
            if (op_reg != OP_WRITE) begin
              rsp_data_reg <= MEM_READ_DATA;
            end
            rsp_latency_reg <= lat_inc;
            rsp_valid_reg   <= 1'b1;
            state_reg       <= S_IDLE;
          end else if (lat_inc >= TIMEOUT_C) begin
            // Cache never answered: abandon the request and freeze until reset.
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            timed_out_reg <= 1'b1;
            state_reg     <= S_HALT;
          end else begin
            lat_reg <= lat_inc;
          end
        end
        S_HALT: begin
          state_reg <= S_HALT;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

`ifdef DCACHE_DRIVER_CHECK_EN
  logic       rsp_mismatch_reg;
  logic [7:0] err_count_reg;
  logic       check_fail;

  // The expected value of a read-check travels in the write-data register.
  assign check_fail = (op_reg == 2'b10) && (MEM_READ_DATA != mem_write_data_reg);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rsp_mismatch_reg <= 1'b0;
      err_count_reg    <= '0;
    end else if (complete) begin
      rsp_mismatch_reg <= check_fail;
      if (check_fail && (err_count_reg != 8'hFF)) begin
        err_count_reg <= err_count_reg + 8'd1;
      end
    end
  end

  assign RSP_MISMATCH = rsp_mismatch_reg;
  assign ERR_COUNT    = err_count_reg;
`else
  assign RSP_MISMATCH = 1'b0;
  assign ERR_COUNT    = 8'd0;
`endif

  assign MEM_READ       = mem_read_reg;
  assign MEM_WRITE      = mem_write_reg;
  assign MEM_ADDRESS    = mem_address_reg;
  assign MEM_WRITE_DATA = mem_write_data_reg;
  assign RSP_VALID      = rsp_valid_reg;
  assign RSP_DATA       = rsp_data_reg;
  assign RSP_LATENCY    = rsp_latency_reg;
  assign TIMED_OUT      = timed_out_reg;
  assign IDLE           = (state_reg == S_IDLE) && (count_reg == '0);

endmodule

// File: tb/tb_dcache_req_driver.sv
// Scoreboard bench for dcache_req_driver: a byte-wide cache model with programmable stall feeds the main instance,
// a second instance with TIMEOUT=8 and a permanently stalled cache exercises the abort path.
module tb_dcache_req_driver;

`ifdef DCACHE_DRIVER_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_address = 8'h00;
  logic [7:0] cmd_data = 8'h00;
  logic       mem_read, mem_write;
  logic [7:0] mem_address, mem_write_data, mem_read_data;
  logic       mem_busy_wait;
  logic       rsp_valid, rsp_mismatch, timed_out, idle;
  logic [7:0] rsp_data, rsp_latency, err_count;

  logic       cmd_valid_t = 1'b0;
  logic       cmd_ready_t;
  logic       mem_read_t, mem_write_t;
  logic [7:0] mem_address_t, mem_write_data_t;
  logic [7:0] mem_read_data_t = 8'h00;
  logic       mem_busy_wait_t = 1'b1;
  logic       rsp_valid_t, rsp_mismatch_t, timed_out_t, idle_t;
  logic [7:0] rsp_data_t, rsp_latency_t, err_count_t;

  always #5 CLK = ~CLK;

  dcache_req_driver #(.FIFO_DEPTH(4), .TIMEOUT(200)) dut (
    .CLK(CLK), .RESET(RESET),
    .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_OP(cmd_op),
    .CMD_ADDRESS(cmd_address), .CMD_DATA(cmd_data),
    .MEM_READ(mem_read), .MEM_WRITE(mem_write), .MEM_ADDRESS(mem_address),
    .MEM_WRITE_DATA(mem_write_data), .MEM_READ_DATA(mem_read_data), .MEM_BUSY_WAIT(mem_busy_wait),
    .RSP_VALID(rsp_valid), .RSP_DATA(rsp_data), .RSP_LATENCY(rsp_latency),
    .RSP_MISMATCH(rsp_mismatch), .ERR_COUNT(err_count), .TIMED_OUT(timed_out), .IDLE(idle)
  );

  dcache_req_driver #(.FIFO_DEPTH(4), .TIMEOUT(8)) dut_t (
    .CLK(CLK), .RESET(RESET),
    .CMD_VALID(cmd_valid_t), .CMD_READY(cmd_ready_t), .CMD_OP(cmd_op),
    .CMD_ADDRESS(cmd_address), .CMD_DATA(cmd_data),
    .MEM_READ(mem_read_t), .MEM_WRITE(mem_write_t), .MEM_ADDRESS(mem_address_t),
    .MEM_WRITE_DATA(mem_write_data_t), .MEM_READ_DATA(mem_read_data_t), .MEM_BUSY_WAIT(mem_busy_wait_t),
    .RSP_VALID(rsp_valid_t), .RSP_DATA(rsp_data_t), .RSP_LATENCY(rsp_latency_t),
    .RSP_MISMATCH(rsp_mismatch_t), .ERR_COUNT(err_count_t), .TIMED_OUT(timed_out_t), .IDLE(idle_t)
  );

  // Cache model: unwritten bytes read as address+2; each request stalls for stall_cfg posedges.
  int           stall_cfg = 0;
  int           wait_cnt = 0;
  logic [7:0]   mdl_mem [256];
  logic [255:0] mdl_valid = '0;

  assign mem_busy_wait = (mem_read || mem_write) && (wait_cnt < stall_cfg);
  assign mem_read_data = mdl_valid[mem_address] ? mdl_mem[mem_address] : mem_address + 8'd2;

  always @(posedge CLK) begin
    if ((mem_read || mem_write) && mem_busy_wait) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
    if (mem_write && !mem_busy_wait && !RESET) begin
      mdl_mem[mem_address]   <= mem_write_data;
      mdl_valid[mem_address] <= 1'b1;
    end
  end

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] lat;
    logic       mis;
    logic [7:0] err;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] ref_mem [256];
  logic [7:0] last_rd = 8'h00;
  logic [7:0] exp_err = 8'h00;

  task automatic apply_reset();
    @(negedge CLK);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    sb.delete();
    last_rd = 8'h00;
    exp_err = 8'h00;
  endtask

  task automatic push_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d, output bit acc);
    exp_t e;
    logic [7:0] rd;
    @(negedge CLK);
    cmd_op = op; cmd_address = a; cmd_data = d; cmd_valid = 1'b1;
    acc = cmd_ready;
    @(posedge CLK);
    #1 cmd_valid = 1'b0;
    if (acc) begin
      if (op == 2'b01) begin
        ref_mem[a] = d;
        rd = last_rd;
      end else begin
        rd = ref_mem[a];
        last_rd = rd;
      end
      e.data = rd;
      e.lat  = (stall_cfg >= 254) ? 8'hFF : 8'(stall_cfg + 1);
      e.mis  = CHECK_EN && (op == 2'b10) && (rd != d);
      if (e.mis && exp_err != 8'hFF) exp_err = exp_err + 8'd1;
      e.err  = exp_err;
      sb.push_back(e);
    end
  endtask

  task automatic push_t(input logic [1:0] op, input logic [7:0] a);
    @(negedge CLK);
    cmd_op = op; cmd_address = a; cmd_data = 8'h00; cmd_valid_t = 1'b1;
    @(posedge CLK);
    #1 cmd_valid_t = 1'b0;
  endtask

  // Watches the main instance for up to budget negedges, scoring every RSP_VALID against the queue.
  task automatic wait_rsp(input int n, input int budget, output int rises, output int hi,
                          output int first_hi, output int first_rsp);
    exp_t e;
    int got;
    bit prev, cur, both, unstable;
    logic [7:0] a0;
    got = 0; rises = 0; hi = 0; first_hi = -1; first_rsp = -1;
    prev = 1'b0; both = 1'b0; unstable = 1'b0; a0 = 8'h00;
    for (int c = 0; c < budget && (n == 0 || got < n); c++) begin
      @(negedge CLK);
      cur = mem_read || mem_write;
      if (mem_read && mem_write) both = 1'b1;
      if (cur && !prev) begin
        rises++;
        a0 = mem_address;
        if (first_hi < 0) first_hi = c;
      end else if (cur && mem_address != a0) begin
        unstable = 1'b1;
      end
      if (cur) hi++;
      prev = cur;
      if (rsp_valid) begin
        got++;
        if (first_rsp < 0) first_rsp = c;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp: rsp_valid=1 with no pending command, required 0");
        end else begin
          e = sb.pop_front();
          checks += 4;
          if (rsp_data !== e.data) begin
            errors++; $display("FAIL rsp_data: got %02h, required %02h", rsp_data, e.data);
          end
          if (rsp_latency !== e.lat) begin
            errors++; $display("FAIL rsp_latency: got %0d, required %0d", rsp_latency, e.lat);
          end
          if (rsp_mismatch !== e.mis) begin
            errors++; $display("FAIL rsp_mismatch: got %b, required %b", rsp_mismatch, e.mis);
          end
          if (err_count !== e.err) begin
            errors++; $display("FAIL err_count: got %0d, required %0d", err_count, e.err);
          end
        end
        $display("rsp: data=%02h latency=%0d mismatch=%b err=%0d", rsp_data, rsp_latency, rsp_mismatch, err_count);
      end
    end
    checks++;
    if (got != n) begin
      errors++; $display("FAIL rsp_count: got %0d responses, required %0d", got, n);
    end
    checks++;
    if (both || unstable) begin
      errors++; $display("FAIL req_protocol: both=%b unstable=%b, required 0 0", both, unstable);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge CLK);
    checks += 4;
    if ({mem_read, mem_write, mem_address, mem_write_data} !== 18'h0) begin
      errors++; $display("FAIL reset_mem: got %b %b %02h %02h, required 0 0 00 00", mem_read, mem_write, mem_address, mem_write_data);
    end
    if ({rsp_valid, rsp_data, rsp_latency, rsp_mismatch, err_count, timed_out} !== 27'h0) begin
      errors++; $display("FAIL reset_rsp: got v=%b d=%02h l=%0d m=%b e=%0d t=%b, required all 0",
                         rsp_valid, rsp_data, rsp_latency, rsp_mismatch, err_count, timed_out);
    end
    if (cmd_ready !== 1'b1 || idle !== 1'b1) begin
      errors++; $display("FAIL reset_ready_idle: got %b %b, required 1 1", cmd_ready, idle);
    end
    if ({mem_read_t, mem_write_t, mem_address_t, mem_write_data_t, rsp_valid_t, rsp_data_t, rsp_latency_t,
         rsp_mismatch_t, err_count_t, timed_out_t, cmd_ready_t, idle_t} !== 47'h3) begin
      errors++; $display("FAIL reset_t: timeout instance outputs not at reset values (timed_out=%b idle=%b)", timed_out_t, idle_t);
    end
    $display("test_reset done");
  endtask

  task automatic test_write_readcheck();
    bit acc;
    int r, h, fh, fr;
    stall_cfg = 0;
    push_cmd(2'b01, 8'h05, 8'hAA, acc);
    wait_rsp(1, 10, r, h, fh, fr);
    checks++;
    if (fh != 1 || fr != 2) begin
      errors++; $display("FAIL zero_wait_timing: req at %0d rsp at %0d, required 1 2", fh, fr);
    end
    push_cmd(2'b10, 8'h05, 8'hAA, acc);
    wait_rsp(1, 10, r, h, fh, fr);
    $display("test_write_readcheck done");
  endtask

  task automatic test_stall_read();
    bit acc;
    int r, h, fh, fr;
    stall_cfg = 18;
    push_cmd(2'b00, 8'h10, 8'h00, acc);
    wait_rsp(1, 60, r, h, fh, fr);
    checks++;
    if (h != 19) begin
      errors++; $display("FAIL stall_req_cycles: got %0d, required 19", h);
    end
    $display("test_stall_read done");
  endtask

  task automatic test_mismatch();
    bit acc;
    int r, h, fh, fr;
    stall_cfg = 0;
    push_cmd(2'b10, 8'h20, 8'h11, acc);
    wait_rsp(1, 10, r, h, fh, fr);
    push_cmd(2'b11, 8'h30, 8'h00, acc);
    wait_rsp(1, 10, r, h, fh, fr);
    $display("test_mismatch done");
  endtask

  task automatic test_back_to_back();
    bit acc;
    int r, h, fh, fr;
    stall_cfg = 0;
    push_cmd(2'b01, 8'h60, 8'h77, acc);
    push_cmd(2'b00, 8'h60, 8'h00, acc);
    wait_rsp(2, 20, r, h, fh, fr);
    checks++;
    if (r != 2) begin
      errors++; $display("FAIL idle_gap: got %0d separate requests, required 2", r);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_fill();
    bit acc;
    bit acc_v [5];
    int r, h, fh, fr;
    logic [1:0] ops [5] = '{2'b01, 2'b00, 2'b10, 2'b01, 2'b00};
    logic [7:0] adr [5] = '{8'h41, 8'h41, 8'h41, 8'h42, 8'h42};
    logic [7:0] dat [5] = '{8'h9C, 8'h00, 8'h9C, 8'h33, 8'h00};
    stall_cfg = 12;
    push_cmd(2'b00, 8'h40, 8'h00, acc);
    @(posedge CLK);
    #1;
    for (int i = 0; i < 5; i++) begin
      push_cmd(ops[i], adr[i], dat[i], acc_v[i]);
      if (i == 3) begin
        checks++;
        if (cmd_ready !== 1'b0) begin
          errors++; $display("FAIL full_ready: got %b after 4th push, required 0", cmd_ready);
        end
      end
    end
    checks++;
    if ({acc_v[0], acc_v[1], acc_v[2], acc_v[3], acc_v[4]} !== 5'b11110) begin
      errors++; $display("FAIL fill_accept: got %b%b%b%b%b, required 11110", acc_v[0], acc_v[1], acc_v[2], acc_v[3], acc_v[4]);
    end
    wait_rsp(5, 100, r, h, fh, fr);
    wait_rsp(0, 20, r, h, fh, fr);
    checks++;
    if (idle !== 1'b1 || r != 0) begin
      errors++; $display("FAIL fill_drain: idle=%b extra_reqs=%0d, required 1 0", idle, r);
    end
    $display("test_fill done");
  endtask

  task automatic test_timeout();
    int h;
    bit seen_rsp;
    apply_reset();
    push_t(2'b00, 8'h70);
    push_t(2'b00, 8'h71);
    h = 0; seen_rsp = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (mem_read_t || mem_write_t) h++;
      if (rsp_valid_t) seen_rsp = 1'b1;
    end
    checks += 3;
    if (h != 8) begin
      errors++; $display("FAIL timeout_req_cycles: got %0d, required 8", h);
    end
    if (timed_out_t !== 1'b1 || seen_rsp) begin
      errors++; $display("FAIL timeout_flag: timed_out=%b rsp_seen=%b, required 1 0", timed_out_t, seen_rsp);
    end
    if (idle_t !== 1'b0 || cmd_ready_t !== 1'b1) begin
      errors++; $display("FAIL halt_state: idle=%b ready=%b, required 0 1", idle_t, cmd_ready_t);
    end
    apply_reset();
    @(negedge CLK);
    checks++;
    if (timed_out_t !== 1'b0 || idle_t !== 1'b1) begin
      errors++; $display("FAIL timeout_clear: timed_out=%b idle=%b, required 0 1", timed_out_t, idle_t);
    end
    $display("test_timeout done");
  endtask

  task automatic test_reset_midreq();
    bit acc;
    int r, h, fh, fr;
    stall_cfg = 100;
    push_cmd(2'b00, 8'h50, 8'h00, acc);
    push_cmd(2'b00, 8'h51, 8'h00, acc);
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    stall_cfg = 0;
    @(posedge CLK);
    #1;
    checks += 2;
    if (mem_read !== 1'b0 || idle !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL midreq_drop: read=%b idle=%b rsp_valid=%b, required 0 1 0", mem_read, idle, rsp_valid);
    end
    if (rsp_latency !== 8'h0 || rsp_data !== 8'h0 || err_count !== 8'h0) begin
      errors++; $display("FAIL midreq_clear: lat=%0d data=%02h err=%0d, required 0 00 0", rsp_latency, rsp_data, err_count);
    end
    @(negedge CLK);
    RESET = 1'b0;
    sb.delete();
    last_rd = 8'h00;
    exp_err = 8'h00;
    wait_rsp(0, 15, r, h, fh, fr);
    checks++;
    if (r != 0) begin
      errors++; $display("FAIL midreq_flush: got %0d requests after reset, required 0", r);
    end
    $display("test_reset_midreq done");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i + 2);
    test_reset();
    test_write_readcheck();
    test_stall_read();
    test_mismatch();
    test_back_to_back();
    test_fill();
    test_timeout();
    test_reset_midreq();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dcache_req_driver.md
# dcache_req_driver

Request initiator for the CPU-side port of the data cache: `dcache_req_driver` replaces the CPU in directed cache benches and built-in cache self-tests. It buffers a queue of read, write and read-check commands and issues them one at a time on the 8-bit READ/WRITE/ADDRESS/WRITEDATA/BUSYWAIT handshake, honouring BUSY_WAIT stalls. It reports returned data, per-request latency, data mismatches and timeouts.

## Interface
Parameters:
- FIFO_DEPTH, 4, command queue depth; power of two, 2..16
- TIMEOUT, 200, maximum REQ cycles before abort; 1..255

Ports:
- CLK  in  1  clock; all state changes on posedge
- RESET  in  1  synchronous, active-high reset
- CMD_VALID  in  1  command push request
- CMD_READY  out  1  queue not full; push accepted on posedge when CMD_VALID & CMD_READY
- CMD_OP  in  2  00 read, 01 write, 10 read-check, 11 reserved (treated as read)
- CMD_ADDRESS  in  8  target byte address
- CMD_DATA  in  8  write data (write) or expected data (read-check)
- MEM_READ  out  1  read request to cache
- MEM_WRITE  out  1  write request to cache
- MEM_ADDRESS  out  8  request address
- MEM_WRITE_DATA  out  8  request write data
- MEM_READ_DATA  in  8  cache read data
- MEM_BUSY_WAIT  in  1  cache stall
- RSP_VALID  out  1  one-cycle completion pulse
- RSP_DATA  out  8  last read data; updated only on read completions
- RSP_LATENCY  out  8  REQ cycles of last completed request, saturating at 255
- RSP_MISMATCH  out  1  valid with RSP_VALID; read-check data differed
- ERR_COUNT  out  8  total mismatches, saturating at 255
- TIMED_OUT  out  1  sticky abort flag
- IDLE  out  1  FSM in IDLE and queue empty

## Operation
- The command queue is a circular FIFO with FIFO_DEPTH entries of 18 bits (op, address, data).
  - Write and read pointers wrap modulo FIFO_DEPTH.
  - The count field is one bit wider than the pointers.
  - A push while full is ignored, because CMD_READY is low.
  - A simultaneous push and pop when not full is legal and leaves the count unchanged.
- FSM state IDLE:
  - If the queue is non-empty: pop the head, register MEM_ADDRESS and MEM_WRITE_DATA, assert MEM_READ (ops 00, 10, 11) or MEM_WRITE (op 01), clear the latency counter, and go to REQ.
  - Otherwise remain in IDLE.
- FSM state REQ:
  - The request is held stable every cycle.
  - The latency counter increments each posedge.
  - Completion occurs at a posedge that samples MEM_BUSY_WAIT=0. On completion:
    - Deassert the request.
    - For reads, capture MEM_READ_DATA into RSP_DATA.
    - Load RSP_LATENCY.
    - For read-check, compare the captured data with the expected value and set RSP_MISMATCH; increment ERR_COUNT on mismatch.
    - Pulse RSP_VALID and go to IDLE.
- Timeout from REQ:
  - Trigger: the latency counter reaches TIMEOUT without completion.
  - Action: drop the request, set TIMED_OUT, go to HALT.
- FSM state HALT:
  - Absorbing; only RESET exits.
  - The queue still accepts pushes while not full.
  - No requests are issued.
- MEM_READ and MEM_WRITE are never both high.
- MEM_* outputs are all registered.

## Timing
- Reset values: MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITE_DATA=0, RSP_VALID=0, RSP_DATA=0, RSP_LATENCY=0, RSP_MISMATCH=0, ERR_COUNT=0, TIMED_OUT=0, CMD_READY=1, IDLE=1. Queue flushed; FSM in IDLE.
- Push accepted at posedge k: the request is asserted after posedge k+1.
- A zero-wait completion is sampled at posedge k+2, with RSP_LATENCY=1. RSP_VALID is high for the cycle following k+2.
- Each stall cycle adds 1 to latency.
- At least one idle cycle separates consecutive requests: the request is low for at least one full cycle.
- RESET high mid-request: at that posedge the request drops, the queue is flushed and all counters clear, even if MEM_BUSY_WAIT=0 at the same edge. No RSP_VALID is generated.

## Configuration
- `DCACHE_DRIVER_CHECK_EN`
  - Defined: read-check compare logic, RSP_MISMATCH and ERR_COUNT are present, as described above.
  - Undefined: op 10 behaves as a plain read, RSP_MISMATCH and ERR_COUNT are tied to 0, and comparator logic is removed.

## Test plan
- Push write 0x05←0xAA then read-check 0x05 expecting 0xAA; cache model with no stall → two RSP_VALID pulses, each RSP_LATENCY=1; RSP_DATA=0xAA, RSP_MISMATCH=0, ERR_COUNT=0.
- Read 0x10 with MEM_BUSY_WAIT held 18 cycles (miss model) → request stable for 19 posedges, RSP_LATENCY=19, RSP_DATA equals model data.
- Read-check 0x20 expecting 0x11, model returns 0x22 → RSP_MISMATCH=1, ERR_COUNT=1; undefine the macro and rerun → RSP_MISMATCH=0, ERR_COUNT=0.
- Hold MEM_BUSY_WAIT high with TIMEOUT=8 → request drops after 8 REQ posedges, TIMED_OUT=1 sticky; further queued commands not issued until RESET.
- Push 5 commands back-to-back with FIFO_DEPTH=4 while stalled → CMD_READY=0 after the 4th push, 5th ignored; all 4 complete in order with pointers wrapping correctly.
- Assert RESET during a stalled request → MEM_READ=0 next cycle, IDLE=1, no RSP_VALID, counters 0.
